// File: rtl/tile_scanner_pkg.sv
// Purpose : shared types and constants for the tile channel scanner.
// Latency : n/a (declarations only).
// Backpress: n/a; freeze_i is the only stall mechanism in the scanner.
package tile_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DWELL  = 2'd3
  } scan_state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

endpackage

// File: rtl/tile_sync2.sv
// Purpose : DATA_W-wide two-flop synchroniser for one asynchronous tile word.
// Latency : 2 enabled cycles from d to q.
// Backpress: en low holds both stages (used to freeze the scanner).
// Ports   : clk, rst_n (async active-low), en, d (async input), q (synced output).
module tile_sync2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else if (en) begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tile_channel_scanner.sv
// Purpose : synchronise NUM_CH tile words; capture one on demand or round-robin scan all.
// Latency : capture accepted at edge T0 -> valid_o in the cycle after edge T0+SETTLE_CYC+1.
// Backpress: none downstream; freeze_i stalls FSM, counters and synchronisers.
// Ports   : ch_data_i (NUM_CH words, async), mode_i, sel_i, capture_i, dwell_i, freeze_i in;
//           data_o, ch_o, valid_o (1-cycle pulse), busy_o, err_o (sticky) out.
// Option  : SCANNER_SAMPLE_CNT_EN adds cnt_o[7:0], a wrapping count of valid_o pulses.
module tile_channel_scanner
  import tile_scanner_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_W     = 8,
  parameter  int SETTLE_CYC = 3,
  parameter  int DWELL_W    = 8,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic                     mode_i,
  input  logic [CH_W-1:0]          sel_i,
  input  logic                     capture_i,
  input  logic [DWELL_W-1:0]       dwell_i,
  input  logic                     freeze_i,
  output logic [DATA_W-1:0]        data_o,
  output logic [CH_W-1:0]          ch_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     err_o
`ifdef SCANNER_SAMPLE_CNT_EN
  ,
  output logic [7:0]               cnt_o
`endif
);

  localparam int              SET_W    = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CH_W:0]    NUM_CH_X = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  logic [DATA_W-1:0] sync [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_sync
    tile_sync2 #(.DATA_W(DATA_W)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~freeze_i),
      .d     (ch_data_i[k*DATA_W +: DATA_W]),
      .q     (sync[k])
    );
  end

  scan_state_t        state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic               err_d;
  logic               fire;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    dwell_d  = dwell_q;
    cur_ch_d = cur_ch_q;
    err_d    = err_o;
    fire     = 1'b0;
    // A frozen cycle leaves every piece of FSM state exactly where it is.
    if (!freeze_i) begin
      unique case (state_q)
        IDLE: begin
          if (mode_i == MODE_AUTO) begin
            state_d  = SETTLE;
            settle_d = '0;
            cur_ch_d = '0;
          end else if (mode_i == MODE_MANUAL && capture_i) begin
            // sel_i can exceed NUM_CH-1 when NUM_CH is not a power of two.
            if ({1'b0, sel_i} < NUM_CH_X) begin
              state_d  = SETTLE;
              settle_d = '0;
              cur_ch_d = sel_i;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (settle_q == SET_LAST) state_d = SAMPLE;
          else                      settle_d = settle_q + 1'b1;
        end
        SAMPLE: begin
          fire    = 1'b1;
          state_d = DWELL;
          dwell_d = dwell_i;  // latched here so later dwell_i edits wait for the next sample
        end
        DWELL: begin
          if (dwell_q == '0) begin
            if (mode_i == MODE_AUTO) begin
              state_d  = SETTLE;
              settle_d = '0;
              cur_ch_d = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            dwell_d = dwell_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      dwell_q  <= '0;
      cur_ch_q <= '0;
      err_o    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      dwell_q  <= dwell_d;
      cur_ch_q <= cur_ch_d;
      err_o    <= err_d;
    end
  end

  // valid_o always drops after one cycle, even if freeze_i rises meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o  <= '0;
      ch_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= fire;
      if (fire) begin
        data_o <= sync[cur_ch_q];
        ch_o   <= cur_ch_q;
      end
    end
  end

  assign busy_o = (state_q != IDLE);

`ifdef SCANNER_SAMPLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_o <= 8'd0;
    else if (fire) cnt_o <= cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_tile_channel_scanner.sv
// Purpose : self-checking bench for tile_channel_scanner (4-channel and 3-channel builds).
// Latency : n/a.
// Backpress: n/a.
module tb_tile_channel_scanner;

  localparam int SC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  // 4-channel instance
  logic [31:0] ch_data4;
  logic        mode4, capture4, freeze4;
  logic [1:0]  sel4;
  logic [7:0]  dwell4;
  logic [7:0]  data_o4;
  logic [1:0]  ch_o4;
  logic        valid_o4, busy_o4, err_o4;
  // 3-channel instance (out-of-range select)
  logic [23:0] ch_data3;
  logic        mode3, capture3, freeze3;
  logic [1:0]  sel3;
  logic [7:0]  dwell3;
  logic [7:0]  data_o3;
  logic [1:0]  ch_o3;
  logic        valid_o3, busy_o3, err_o3;
`ifdef SCANNER_SAMPLE_CNT_EN
  logic [7:0]  cnt_o4, cnt_o3;
`endif

  tile_channel_scanner #(.NUM_CH(4), .DATA_W(8), .SETTLE_CYC(SC), .DWELL_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .ch_data_i(ch_data4), .mode_i(mode4), .sel_i(sel4),
    .capture_i(capture4), .dwell_i(dwell4), .freeze_i(freeze4), .data_o(data_o4),
    .ch_o(ch_o4), .valid_o(valid_o4), .busy_o(busy_o4), .err_o(err_o4)
`ifdef SCANNER_SAMPLE_CNT_EN
    , .cnt_o(cnt_o4)
`endif
  );

  tile_channel_scanner #(.NUM_CH(3), .DATA_W(8), .SETTLE_CYC(SC), .DWELL_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .ch_data_i(ch_data3), .mode_i(mode3), .sel_i(sel3),
    .capture_i(capture3), .dwell_i(dwell3), .freeze_i(freeze3), .data_o(data_o3),
    .ch_o(ch_o3), .valid_o(valid_o3), .busy_o(busy_o3), .err_o(err_o3)
`ifdef SCANNER_SAMPLE_CNT_EN
    , .cnt_o(cnt_o3)
`endif
  );

  typedef struct {
    int         c;
    logic [7:0] d;
    logic [1:0] ch;
  } vrec_t;

  vrec_t q4[$];
  vrec_t q3[$];
  int    nvalid4 = 0;

  // Record every valid pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (valid_o4) begin
      q4.push_back('{c: cyc, d: data_o4, ch: ch_o4});
      nvalid4++;
    end
    if (valid_o3) q3.push_back('{c: cyc, d: data_o3, ch: ch_o3});
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] chv4 [4];
  logic [7:0] chv3 [3];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ch();
    for (int k = 0; k < 4; k++) ch_data4[k*8 +: 8] = chv4[k];
    for (int k = 0; k < 3; k++) ch_data3[k*8 +: 8] = chv3[k];
  endtask

  task automatic wait_v(input bit is3, input int budget, output vrec_t r);
    int n;
    n = 0;
    r = '{c: -1, d: 8'h0, ch: 2'h0};
    while (((is3 ? q3.size() : q4.size()) == 0) && n < budget) begin
      tick();
      n++;
    end
    check(is3 ? "valid3_seen" : "valid4_seen",
          32'((is3 ? q3.size() : q4.size()) != 0), 32'd1);
    if (!is3 && q4.size() != 0) r = q4.pop_front();
    if (is3 && q3.size() != 0)  r = q3.pop_front();
  endtask

  initial begin
    vrec_t      r;
    int         n0, v0, per, snap;
    logic [1:0] sel;
    logic [7:0] dw;

    rst_n = 1'b0;
    mode4 = 1'b0; capture4 = 1'b0; freeze4 = 1'b0; sel4 = 2'd0; dwell4 = 8'd0;
    mode3 = 1'b0; capture3 = 1'b0; freeze3 = 1'b0; sel3 = 2'd0; dwell3 = 8'd0;
    for (int k = 0; k < 4; k++) chv4[k] = 8'($urandom);
    for (int k = 0; k < 3; k++) chv3[k] = 8'($urandom);
    drive_ch();
    repeat (3) tick();
    check("reset_out4", 32'({data_o4, ch_o4, valid_o4, busy_o4, err_o4}), 32'd0);
    check("reset_err3", 32'(err_o3), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Manual captures: latency SETTLE_CYC+2 from the driving cycle.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) chv4[k] = 8'($urandom);
      sel = (i == 0) ? 2'd2 : 2'($urandom_range(0, 3));
      if (i == 0) chv4[2] = 8'hA5;
      dw = (i == 0) ? 8'd0 : 8'($urandom_range(0, 3));
      drive_ch();
      dwell4 = dw;
      sel4 = sel;
      repeat (3) tick();
      n0 = cyc;
      capture4 = 1'b1;
      tick();
      capture4 = 1'b0;
      if (i == 1) begin
        // A request while busy must be dropped, not queued.
        tick();
        sel4 = sel + 2'd1;
        capture4 = 1'b1;
        tick();
        capture4 = 1'b0;
      end
      wait_v(1'b0, 20, r);
      check("man_latency", 32'(r.c - n0), 32'(SC + 2));
      check("man_data", 32'(r.d), 32'(chv4[sel]));
      check("man_ch", 32'(r.ch), 32'(sel));
      while (cyc < r.c + int'(dw)) tick();
      check("man_busy_dwell", 32'(busy_o4), 32'd1);
      tick();
      check("man_busy_idle", 32'(busy_o4), 32'd0);
      repeat (6) tick();
      check("man_no_extra", 32'(q4.size()), 32'd0);
    end

    // Auto scan with dwell 0, fixed channel values, through the wrap.
    chv4[0] = 8'h11; chv4[1] = 8'h22; chv4[2] = 8'h33; chv4[3] = 8'h44;
    drive_ch();
    dwell4 = 8'd0;
    repeat (3) tick();
    n0 = cyc;
    mode4 = 1'b1;
    per = SC + 2;
    for (int j = 0; j < 5; j++) begin
      wait_v(1'b0, 30, r);
      check("auto_ch", 32'(r.ch), 32'(j % 4));
      check("auto_data", 32'(r.d), 32'(chv4[j % 4]));
      check("auto_cycle", 32'(r.c), 32'(n0 + SC + 2 + j * per));
    end
    mode4 = 1'b0;
    tick();
    check("auto_stop_idle", 32'(busy_o4), 32'd0);
    repeat (10) tick();
    check("auto_stop_none", 32'(q4.size()), 32'd0);

    // Auto scan with random dwell; drop mode during the second ch1 dwell.
    for (int k = 0; k < 4; k++) chv4[k] = 8'($urandom);
    dw = 8'($urandom_range(1, 3));
    drive_ch();
    dwell4 = dw;
    repeat (3) tick();
    n0 = cyc;
    mode4 = 1'b1;
    per = SC + 2 + int'(dw);
    for (int j = 0; j < 6; j++) begin
      wait_v(1'b0, 40, r);
      check("rauto_ch", 32'(r.ch), 32'(j % 4));
      check("rauto_data", 32'(r.d), 32'(chv4[j % 4]));
      check("rauto_cycle", 32'(r.c), 32'(n0 + SC + 2 + j * per));
    end
    mode4 = 1'b0;
    while (cyc < r.c + int'(dw)) tick();
    check("msw_busy_dwell", 32'(busy_o4), 32'd1);
    tick();
    check("msw_busy_idle", 32'(busy_o4), 32'd0);
    repeat (20) tick();
    check("msw_no_ch2", 32'(q4.size()), 32'd0);

    // Freeze for 10 cycles inside a dwell of 4; dwell_i edit must not affect it.
    for (int k = 0; k < 4; k++) chv4[k] = 8'($urandom);
    drive_ch();
    dwell4 = 8'd4;
    repeat (3) tick();
    n0 = cyc;
    mode4 = 1'b1;
    wait_v(1'b0, 30, r);
    check("frz_first_cycle", 32'(r.c), 32'(n0 + SC + 2));
    v0 = r.c;
    tick();
    freeze4 = 1'b1;
    dwell4 = 8'd1;
    snap = nvalid4;
`ifdef SCANNER_SAMPLE_CNT_EN
    check("frz_cnt_before", 32'(cnt_o4), 32'(nvalid4 % 256));
`endif
    repeat (10) tick();
    freeze4 = 1'b0;
    check("frz_no_valid", 32'(nvalid4 - snap), 32'd0);
`ifdef SCANNER_SAMPLE_CNT_EN
    check("frz_cnt_held", 32'(cnt_o4), 32'(snap % 256));
`endif
    wait_v(1'b0, 40, r);
    mode4 = 1'b0;
    check("frz_next_cycle", 32'(r.c), 32'(v0 + SC + 2 + 4 + 10));
    check("frz_next_ch", 32'(r.ch), 32'd1);
    check("frz_next_data", 32'(r.d), 32'(chv4[1]));
    repeat (8) tick();
    check("frz_idle", 32'(busy_o4), 32'd0);

    // Out-of-range select on the 3-channel build.
    sel3 = 2'd3;
    capture3 = 1'b1;
    tick();
    capture3 = 1'b0;
    check("oor_err", 32'(err_o3), 32'd1);
    check("oor_busy", 32'(busy_o3), 32'd0);
    repeat (10) tick();
    check("oor_no_valid", 32'(q3.size()), 32'd0);
    for (int k = 0; k < 3; k++) chv3[k] = 8'($urandom);
    drive_ch();
    sel = 2'($urandom_range(0, 2));
    sel3 = sel;
    repeat (3) tick();
    n0 = cyc;
    capture3 = 1'b1;
    tick();
    capture3 = 1'b0;
    wait_v(1'b1, 20, r);
    check("oor_ok_latency", 32'(r.c - n0), 32'(SC + 2));
    check("oor_ok_data", 32'(r.d), 32'(chv3[sel]));
    check("oor_ok_ch", 32'(r.ch), 32'(sel));
    check("oor_err_sticky", 32'(err_o3), 32'd1);

    // Reset in the middle of SETTLE.
    sel4 = 2'd3;
    capture4 = 1'b1;
    tick();
    capture4 = 1'b0;
    tick();
    check("pre_rst_busy", 32'(busy_o4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_out4", 32'({data_o4, ch_o4, valid_o4, busy_o4, err_o4}), 32'd0);
    check("rst_err3", 32'(err_o3), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("post_rst_idle", 32'(busy_o4), 32'd0);
    check("post_rst_none", 32'(q4.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tile_channel_scanner.md
# tile_channel_scanner

Parametrised successor to the micro-tile container's static output select. Takes `NUM_CH` sensor-channel words (sensor, TDC, ring-oscillator tiles and any future tiles), passes each through a 2-flop synchroniser, and either captures one operator-selected channel on demand or round-robin scans all channels with a programmable dwell. It sits between the tile instances and the top-level `uo_out` mux and delivers glitch-free, time-stamped snapshots instead of raw asynchronous tile outputs.

## Interface
- `NUM_CH`, 4: number of tile channels; 2..16.
- `DATA_W`, 8: width of each channel word and of `data_o`.
- `SETTLE_CYC`, 3: cycles spent in SETTLE after a channel switch; must be ≥2, which covers the synchroniser.
- `DWELL_W`, 8: width of `dwell_i`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `ch_data_i` in `NUM_CH*DATA_W`: channel k occupies bits [k*DATA_W +: DATA_W]; asynchronous to `clk`.
- `mode_i` in 1: 0 = manual, 1 = auto-scan.
- `sel_i` in `CH_W = $clog2(NUM_CH)`: manual channel select.
- `capture_i` in 1: manual capture request, level-sampled in IDLE.
- `dwell_i` in `DWELL_W`: extra hold cycles after each sample.
- `freeze_i` in 1: stalls the FSM and all counters while high.
- `data_o` out `DATA_W`: last sampled word.
- `ch_o` out `CH_W`: channel index of `data_o`.
- `valid_o` out 1: one-cycle pulse when `data_o` and `ch_o` update.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `err_o` out 1: sticky; set by a manual capture with `sel_i` ≥ `NUM_CH`.

## Operation
- Synchroniser: every channel word passes through 2 flops. All further logic uses the synced copy `sync[k]`.
- FSM states:
  - IDLE:
    - `mode_i`=1 → SETTLE, `cur_ch`←0.
    - `mode_i`=0 and `capture_i`=1 and `sel_i`<`NUM_CH` → SETTLE, `cur_ch`←`sel_i`.
    - `sel_i`≥`NUM_CH` → stay in IDLE, `err_o`←1.
  - SETTLE: `cnt` counts from 0; → SAMPLE when `cnt`==`SETTLE_CYC`-1.
  - SAMPLE: single cycle. `data_o`←`sync[cur_ch]`, `ch_o`←`cur_ch`, `valid_o`←1 for the next cycle. → DWELL.
  - DWELL: lasts `dwell_i`+1 cycles. `dwell_i` is sampled on DWELL entry; later changes do not affect the running dwell. On exit:
    - `mode_i`=1 → SETTLE with `cur_ch`←`cur_ch`+1, wrapping `NUM_CH`-1→0.
    - Otherwise → IDLE.
- `mode_i` is examined only in IDLE and at DWELL exit. Toggling it mid-sequence completes the current sample first.
- `capture_i` is ignored outside IDLE; requests are not queued.
- `freeze_i`=1: state, `cnt`, `cur_ch` and the synchroniser output registers are unchanged and no `valid_o` is issued. A `valid_o` already asserted still completes its single cycle.
- Reset values: every output is 0; state is IDLE; `cnt`, `cur_ch` and the synchronisers are 0.
- Reset mid-operation aborts immediately and returns to the reset values. There is no partial `valid_o`.

## Timing
- Manual: `capture_i` seen in IDLE at edge T0 gives `valid_o` high in the cycle after edge T0+`SETTLE_CYC`+1. With default parameters that is 4 cycles after the capture edge.
- Auto period per channel is `SETTLE_CYC`+1+(`dwell_i`+1) cycles. Defaults with `dwell_i`=0 give 5 cycles.
- Data age: `data_o` reflects `ch_data_i` as it was 2–3 cycles before the SAMPLE edge.
- `busy_o` rises the cycle after the accepting IDLE edge and falls the cycle after DWELL exits to IDLE.

## Configuration
- `SCANNER_SAMPLE_CNT_EN` defined:
  - Adds output `cnt_o` [7:0], a free-running sample counter.
  - Increments on every `valid_o` and wraps 255→0.
  - Reset value 0; held while `freeze_i`=1.
- Undefined: port `cnt_o` is absent and no counter logic is generated.

## Structure
- Package `tile_scanner_pkg` holds:
  - State enum `scan_state_t` {IDLE, SETTLE, SAMPLE, DWELL}.
  - Mode constants `MODE_MANUAL`=0, `MODE_AUTO`=1.
- Sub-module `tile_sync2`: `DATA_W`-wide 2-flop synchroniser with async active-low reset and an enable input. Enable is tied to `~freeze_i`. One instance per channel via a generate loop.

## Test plan
- Reset: drive `rst_n`=0 mid-SETTLE → all outputs 0 and state IDLE within the same cycle. Release → stays IDLE with `mode_i`=0.
- Manual capture: `ch_data_i` ch2=8'hA5, `sel_i`=2, pulse `capture_i` → `valid_o` 4 cycles later, `data_o`=A5, `ch_o`=2, then IDLE.
- Auto-scan: channels = {11,22,33,44}, `dwell_i`=0 → `valid_o` every 5 cycles with `ch_o` sequence 0,1,2,3,0. `data_o` tracks each channel value; wrap verified.
- Out-of-range select: `NUM_CH`=3, `sel_i`=3, capture → no `valid_o`, `err_o`=1, which stays set after a subsequent valid capture.
- Freeze: assert `freeze_i` for 10 cycles in DWELL with `dwell_i`=4 → the next `valid_o` is delayed by exactly 10 cycles. With `SCANNER_SAMPLE_CNT_EN`, `cnt_o` does not advance during the freeze.
- Mode switch: set `mode_i`=0 during auto DWELL of ch1 → ch1 sample completes, FSM returns to IDLE, no ch2 sample issued.
